csr_trap_file: RTL and testbench

- Trap-state register file sitting directly upstream of the exception controller.
- Holds STATUS, SCAUSE, INTMASK, SEPC, STVEC and a trap counter, and accumulates exception causes raised by decode/execute.
- Drives STATUS/SCAUSE/INTMASK into the exception controller. Consumes its EXL_Set and INT_PEND outputs plus the core's int_ret to perform trap entry and return.
- Issues a registered PC-redirect pulse to the fetch stage on each entry and each return.

---
 rtl/csr_trap_file_pkg.sv | 32 +++
 rtl/csr_trap_file.sv | 112 +++++++++++
 tb/tb_csr_trap_file.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_file_pkg.sv
// Shared encodings for the trap-state CSR file: CSR addresses, STATUS bit
// positions and the one-hot SCAUSE cause bits used by decode/execute.
package csr_trap_file_pkg;

   typedef enum logic [2:0] {
      CSR_STATUS  = 3'd0,
      CSR_SCAUSE  = 3'd1,
      CSR_INTMASK = 3'd2,
      CSR_SEPC    = 3'd3,
      CSR_STVEC   = 3'd4,
      CSR_TCOUNT  = 3'd5
   } csr_addr_e;

   localparam int ST_EXL      = 0;
   localparam int ST_IE       = 1;
   localparam int ST_PIE      = 2;
   localparam int ST_NEST_ERR = 3;

   localparam logic [7:0] SC_MISALIGN_FETCH = 8'h01;
   localparam logic [7:0] SC_FETCH_FAULT    = 8'h02;
   localparam logic [7:0] SC_ILLEGAL        = 8'h04;
   localparam logic [7:0] SC_BREAK          = 8'h08;
   localparam logic [7:0] SC_MISALIGN_LS    = 8'h10;
   localparam logic [7:0] SC_LS_FAULT       = 8'h20;
   localparam logic [7:0] SC_ECALL          = 8'h40;
   localparam logic [7:0] SC_IRQ            = 8'h80;

   localparam logic [7:0] SC_ALL = SC_MISALIGN_FETCH | SC_FETCH_FAULT | SC_ILLEGAL |
                                   SC_BREAK | SC_MISALIGN_LS | SC_LS_FAULT |
                                   SC_ECALL | SC_IRQ;

endpackage

// File: rtl/csr_trap_file.sv
// Trap-state register file: STATUS/SCAUSE/INTMASK/SEPC/STVEC/TCOUNT, trap
// entry and return sequencing, and a registered PC-redirect pulse to fetch.
module csr_trap_file
   import csr_trap_file_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] STVEC_RESET = 32'h0000_1000,
   parameter int              VEC_SHIFT   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_we,
   input  logic [2:0]      csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   input  logic [7:0]      exc_raise,
   input  logic [XLEN-1:0] exc_pc,
   input  logic            EXL_Set,
   input  logic [2:0]      INT_PEND,
   input  logic            int_ret,
   output logic [7:0]      STATUS,
   output logic [7:0]      SCAUSE,
   output logic [7:0]      INTMASK,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   logic [3:0]      status_q, status_d;
   logic [7:0]      scause_q, intmask_q, w1c;
   logic [XLEN-1:0] sepc_q, stvec_q, tcount_q, vec_target;
   logic            wr_status, wr_intmask, wr_sepc, wr_stvec, wr_tcount;
   logic            trap_ret, trap_entry, trap_nest;

   assign wr_status  = csr_we && (csr_addr == CSR_STATUS);
   assign wr_intmask = csr_we && (csr_addr == CSR_INTMASK);
   assign wr_sepc    = csr_we && (csr_addr == CSR_SEPC);
   assign wr_stvec   = csr_we && (csr_addr == CSR_STVEC);
   assign wr_tcount  = csr_we && (csr_addr == CSR_TCOUNT);
   assign w1c        = (csr_we && (csr_addr == CSR_SCAUSE)) ? csr_wdata[7:0] : 8'h00;

   // A return always wins; an entry request in the same cycle is dropped and re-raised later.
   assign trap_ret   = int_ret;
   assign trap_entry = EXL_Set && !int_ret && !status_q[ST_EXL];
   assign trap_nest  = EXL_Set && !int_ret &&  status_q[ST_EXL];

   assign vec_target = stvec_q + (XLEN'(INT_PEND) << VEC_SHIFT);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      status_d = status_q;
      if (trap_ret) begin
         status_d[ST_EXL] = 1'b0;
         status_d[ST_IE]  = status_q[ST_PIE];
         status_d[ST_PIE] = 1'b1;
      end else if (trap_entry) begin
         status_d[ST_PIE] = status_q[ST_IE];
         status_d[ST_IE]  = 1'b0;
         status_d[ST_EXL] = 1'b1;
      end else begin
         if (wr_status) status_d = csr_wdata[3:0];
         if (trap_nest) status_d[ST_NEST_ERR] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q       <= '0;
         scause_q       <= '0;
         intmask_q      <= '0;
         sepc_q         <= '0;
         stvec_q        <= STVEC_RESET;
         tcount_q       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         status_q       <= status_d;
         scause_q       <= (scause_q & ~w1c) | (exc_raise & SC_ALL);
         redirect_valid <= trap_entry || trap_ret;

         if (wr_intmask) intmask_q <= csr_wdata[7:0];
         if (wr_stvec)   stvec_q   <= csr_wdata;

         if (trap_entry)                 sepc_q <= exc_pc;
         else if (wr_sepc && !trap_ret)  sepc_q <= csr_wdata;

         if (trap_entry)     tcount_q <= tcount_q + 1'b1;
         else if (wr_tcount) tcount_q <= csr_wdata;

         if (trap_ret)        redirect_pc <= sepc_q;
         else if (trap_entry) redirect_pc <= vec_target;
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_STATUS:  csr_rdata = XLEN'(status_q);
         CSR_SCAUSE:  csr_rdata = XLEN'(scause_q);
         CSR_INTMASK: csr_rdata = XLEN'(intmask_q);
         CSR_SEPC:    csr_rdata = sepc_q;
         CSR_STVEC:   csr_rdata = stvec_q;
         CSR_TCOUNT:  csr_rdata = tcount_q;
         default:     csr_rdata = '0;
      endcase
   end

   assign STATUS  = {4'b0000, status_q};
   assign SCAUSE  = scause_q;
   assign INTMASK = intmask_q;

endmodule

// File: tb/tb_csr_trap_file.sv
// Scoreboard bench for csr_trap_file: expectations are queued as stimulus is
// driven and compared against DUT outputs shortly after the following edge.
module tb_csr_trap_file;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            csr_we;
   logic [2:0]      csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic [7:0]      exc_raise;
   logic [XLEN-1:0] exc_pc;
   logic            EXL_Set;
   logic [2:0]      INT_PEND;
   logic            int_ret;
   logic [7:0]      STATUS;
   logic [7:0]      SCAUSE;
   logic [7:0]      INTMASK;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   csr_trap_file dut (
      .clk            (clk),
      .rst            (rst),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .exc_raise      (exc_raise),
      .exc_pc         (exc_pc),
      .EXL_Set        (EXL_Set),
      .INT_PEND       (INT_PEND),
      .int_ret        (int_ret),
      .STATUS         (STATUS),
      .SCAUSE         (SCAUSE),
      .INTMASK        (INTMASK),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef enum int {O_RV, O_RPC, O_STATUS, O_SCAUSE, O_INTMASK, O_CSR} obs_e;

   string           tag_q[$];
   obs_e            what_q[$];
   logic [2:0]      addr_q[$];
   logic [XLEN-1:0] exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic expect_out(input string tag, input obs_e what, input logic [XLEN-1:0] exp);
      tag_q.push_back(tag);
      what_q.push_back(what);
      addr_q.push_back(3'd0);
      exp_q.push_back(exp);
   endtask

   task automatic expect_csr(input string tag, input logic [2:0] addr, input logic [XLEN-1:0] exp);
      tag_q.push_back(tag);
      what_q.push_back(O_CSR);
      addr_q.push_back(addr);
      exp_q.push_back(exp);
   endtask

   task automatic drain();
      logic [XLEN-1:0] act;
      while (exp_q.size() > 0) begin
         string           t = tag_q.pop_front();
         obs_e            w = what_q.pop_front();
         logic [2:0]      a = addr_q.pop_front();
         logic [XLEN-1:0] e = exp_q.pop_front();
         case (w)
            O_RV:      act = XLEN'(redirect_valid);
            O_RPC:     act = redirect_pc;
            O_STATUS:  act = XLEN'(STATUS);
            O_SCAUSE:  act = XLEN'(SCAUSE);
            O_INTMASK: act = XLEN'(INTMASK);
            default: begin
               csr_we   = 1'b0;
               csr_addr = a;
               #1;
               act = csr_rdata;
            end
         endcase
         check(t, act, e);
      end
   endtask

   task automatic idle();
      csr_we    = 1'b0;
      csr_addr  = 3'd0;
      csr_wdata = '0;
      exc_raise = 8'h00;
      exc_pc    = '0;
      EXL_Set   = 1'b0;
      INT_PEND  = 3'd0;
      int_ret   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
      idle();
   endtask

   task automatic csr_write(input logic [2:0] addr, input logic [XLEN-1:0] data);
      csr_we    = 1'b1;
      csr_addr  = addr;
      csr_wdata = data;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      expect_out("rst_status", O_STATUS, 32'h00);
      expect_out("rst_scause", O_SCAUSE, 32'h00);
      expect_out("rst_intmask", O_INTMASK, 32'h00);
      expect_out("rst_rv", O_RV, 32'h0);
      expect_out("rst_rpc", O_RPC, 32'h0);
      expect_csr("rst_stvec", 3'd4, 32'h0000_1000);
      drain();
      @(negedge clk);
      rst = 1'b0;

      // Mid-operation async reset while a redirect is live
      csr_write(3'd4, 32'h2000);                 tick();
      csr_write(3'd0, 32'h2);                    tick();
      csr_write(3'd2, 32'hFF); exc_raise = 8'h10;
      expect_out("pre_intmask", O_INTMASK, 32'hFF);
      expect_out("pre_scause", O_SCAUSE, 32'h10);
      tick();
      EXL_Set = 1'b1; INT_PEND = 3'd1; exc_pc = 32'h80;
      expect_out("pre_rv", O_RV, 32'h1);
      expect_out("pre_rpc", O_RPC, 32'h2004);
      tick();
      rst = 1'b1;
      #2;
      expect_out("arst_rv", O_RV, 32'h0);
      expect_out("arst_rpc", O_RPC, 32'h0);
      expect_out("arst_status", O_STATUS, 32'h0);
      expect_out("arst_scause", O_SCAUSE, 32'h0);
      expect_out("arst_intmask", O_INTMASK, 32'h0);
      expect_csr("arst_stvec", 3'd4, 32'h0000_1000);
      expect_csr("arst_sepc", 3'd3, 32'h0);
      expect_csr("arst_tcount", 3'd5, 32'h0);
      drain();
      @(negedge clk);
      rst = 1'b0;

      // Trap entry
      csr_write(3'd0, 32'h2);                    tick();
      EXL_Set = 1'b1; INT_PEND = 3'd2; exc_pc = 32'h400;
      expect_out("entry_rv", O_RV, 32'h1);
      expect_out("entry_rpc", O_RPC, 32'h1008);
      expect_out("entry_status", O_STATUS, 32'h05);
      expect_csr("entry_sepc", 3'd3, 32'h400);
      expect_csr("entry_tcount", 3'd5, 32'h1);
      tick();
      expect_out("entry_rv_drop", O_RV, 32'h0);
      tick();

      // Trap return
      int_ret = 1'b1;
      expect_out("ret_rv", O_RV, 32'h1);
      expect_out("ret_rpc", O_RPC, 32'h400);
      expect_out("ret_status", O_STATUS, 32'h06);
      tick();

      // Nested entry
      EXL_Set = 1'b1; INT_PEND = 3'd0; exc_pc = 32'h500;
      expect_out("entry2_rpc", O_RPC, 32'h1000);
      expect_out("entry2_status", O_STATUS, 32'h05);
      tick();
      EXL_Set = 1'b1; INT_PEND = 3'd3; exc_pc = 32'h600;
      expect_out("nest_rv", O_RV, 32'h0);
      expect_out("nest_status", O_STATUS, 32'h0D);
      expect_out("nest_rpc", O_RPC, 32'h1000);
      expect_csr("nest_sepc", 3'd3, 32'h500);
      expect_csr("nest_tcount", 3'd5, 32'h2);
      tick();
      csr_write(3'd0, 32'h05);
      expect_out("nest_clear", O_STATUS, 32'h05);
      tick();

      // SCAUSE set/clear race
      exc_raise = 8'h03;
      expect_out("sc_set", O_SCAUSE, 32'h03);
      tick();
      csr_write(3'd1, 32'h01); exc_raise = 8'h01;
      expect_out("sc_race", O_SCAUSE, 32'h03);
      tick();
      csr_write(3'd1, 32'h03);
      expect_out("sc_clear", O_SCAUSE, 32'h00);
      tick();

      // Simultaneous entry and return: return wins
      csr_write(3'd3, 32'h40);
      expect_csr("sepc_wr", 3'd3, 32'h40);
      tick();
      EXL_Set = 1'b1; int_ret = 1'b1; INT_PEND = 3'd7; exc_pc = 32'h999;
      expect_out("both_rv", O_RV, 32'h1);
      expect_out("both_rpc", O_RPC, 32'h40);
      expect_out("both_status", O_STATUS, 32'h06);
      expect_csr("both_tcount", 3'd5, 32'h2);
      expect_csr("both_sepc", 3'd3, 32'h40);
      tick();

      // Return with EXL=0 beats a same-cycle SEPC write
      int_ret = 1'b1; csr_write(3'd3, 32'h123);
      expect_out("ret0_rpc", O_RPC, 32'h40);
      expect_out("ret0_status", O_STATUS, 32'h06);
      expect_csr("ret0_sepc", 3'd3, 32'h40);
      tick();

      // TCOUNT wrap
      csr_write(3'd5, 32'hFFFF_FFFF);            tick();
      EXL_Set = 1'b1; INT_PEND = 3'd7; exc_pc = 32'h700;
      expect_out("wrap_rpc", O_RPC, 32'h101C);
      expect_csr("wrap_tcount", 3'd5, 32'h0);
      tick();

      // Redirect target wraps modulo 2^XLEN; unmapped address reads 0
      int_ret = 1'b1;                            tick();
      csr_write(3'd4, 32'hFFFF_FFF0);            tick();
      csr_write(3'd7, 32'hDEAD_BEEF);            tick();
      EXL_Set = 1'b1; INT_PEND = 3'd7; exc_pc = 32'h800;
      expect_out("vec_wrap_rpc", O_RPC, 32'h0000_000C);
      expect_csr("unmapped_rd", 3'd6, 32'h0);
      expect_csr("unmapped_rd7", 3'd7, 32'h0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
